// File: rtl/quad_warp_pkg.sv
// Shared types and width helpers for the quad warp mapper.
package quad_warp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_DIV,
    ROW_DIV,
    STREAM,
    DRAIN
  } state_t;

  // Corner storage is sized for the widest supported coordinate.
  localparam int CRD_W = 16;

  typedef struct packed {
    logic [CRD_W-1:0] x;
    logic [CRD_W-1:0] y;
  } corner_t;

  // Divider width: magnitude of a fixed-point difference plus one guard bit.
  function automatic int quot_width(input int x_bits, input int frac_bits);
    return x_bits + frac_bits + 1;
  endfunction

  // Signed accumulator / delta width.
  function automatic int acc_width(input int x_bits, input int frac_bits);
    return x_bits + frac_bits + 2;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// i_start loads the operands (one cycle); o_done and o_quotient are valid
// together during the final iteration cycle, so a divide occupies W+1 cycles.
module seq_divider #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_dsr;
  logic [W-1:0]     r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [W:0]   w_shift;
  logic         w_ge;
  logic [W-1:0] w_rem_next;

  // Trial subtraction for the current quotient bit.
  always_comb begin
    w_shift    = {r_rem, r_quo[W-1]};
    w_ge       = (w_shift >= {1'b0, r_dsr});
    w_rem_next = w_ge ? W'(w_shift - {1'b0, r_dsr}) : w_shift[W-1:0];
  end

  // Load on start, then shift one quotient bit in per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo  <= '0;
      r_dsr  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_dsr  <= i_divisor;
      r_rem  <= '0;
      r_cnt  <= CNT_W'(W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= {r_quo[W-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == CNT_W'(1));
  assign o_quotient = {r_quo[W-2:0], w_ge};

endmodule

// File: rtl/quad_warp_mapper.sv
// Bilinear corner-driven mapper: streams raster source pixels out with their
// interpolated destination coordinate. Edge and row deltas share one divider.
// Optional build macro CLIP_OUTPUT_EN: out-of-range pixels are consumed
// silently instead of being emitted with wrapped coordinates.
// Assumes Y_BITS <= X_BITS.
module quad_warp_mapper
  import quad_warp_pkg::*;
#(
  parameter int SRC_W     = 640,
  parameter int SRC_H     = 480,
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 9,
  parameter int FRAC_BITS = 10,
  parameter int PIX_BITS  = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                corners_valid,
  output logic                corners_ready,
  input  logic [X_BITS-1:0]   a_x,
  input  logic [X_BITS-1:0]   b_x,
  input  logic [X_BITS-1:0]   c_x,
  input  logic [X_BITS-1:0]   d_x,
  input  logic [Y_BITS-1:0]   a_y,
  input  logic [Y_BITS-1:0]   b_y,
  input  logic [Y_BITS-1:0]   c_y,
  input  logic [Y_BITS-1:0]   d_y,
  input  logic [PIX_BITS-1:0] pix_in,
  input  logic                pix_in_valid,
  output logic                pix_in_ready,
  output logic [PIX_BITS-1:0] pix_out,
  output logic [X_BITS-1:0]   out_x,
  output logic [Y_BITS-1:0]   out_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_done
);
  localparam int QW    = quot_width(X_BITS, FRAC_BITS);
  localparam int ACC_W = acc_width(X_BITS, FRAC_BITS);
  localparam int NUM_W = ACC_W + 1;
  localparam int COL_W = $clog2(SRC_W);
  localparam int ROW_W = $clog2(SRC_H);

  state_t                    r_state;
  corner_t                   r_a, r_b, r_c, r_d;
  logic [1:0]                r_div_idx;
  logic                      r_neg;
  logic signed [ACC_W-1:0]   r_lx, r_ly, r_rx, r_ry, r_px, r_py;
  logic signed [ACC_W-1:0]   r_dlx, r_dly, r_drx, r_dry, r_hx, r_hy;
  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic [PIX_BITS-1:0]       r_pix;
  logic [X_BITS-1:0]         r_x;
  logic [Y_BITS-1:0]         r_y;
  logic                      r_valid;
  logic                      r_frame_done;

  logic signed [NUM_W-1:0]   w_num;
  logic                      w_neg;
  logic [QW-1:0]             w_dividend;
  logic [QW-1:0]             w_divisor;
  logic [QW-1:0]             w_quo;
  logic                      w_div_busy;
  logic                      w_div_done;
  logic                      w_div_start;
  logic signed [ACC_W-1:0]   w_delta;
  logic                      w_pix_ready;
  logic                      w_accept;
  logic                      w_emit;

  // Select the signed numerator for the divide in progress and split sign/magnitude.
  always_comb begin
    w_num = '0;
    if (r_state == FRAME_DIV) begin
      case (r_div_idx)
        2'd0:    w_num = $signed(NUM_W'(r_d.x) - NUM_W'(r_a.x)) <<< FRAC_BITS;
        2'd1:    w_num = $signed(NUM_W'(r_d.y) - NUM_W'(r_a.y)) <<< FRAC_BITS;
        2'd2:    w_num = $signed(NUM_W'(r_c.x) - NUM_W'(r_b.x)) <<< FRAC_BITS;
        default: w_num = $signed(NUM_W'(r_c.y) - NUM_W'(r_b.y)) <<< FRAC_BITS;
      endcase
    end else if (r_div_idx[0]) begin
      w_num = NUM_W'(r_ry) - NUM_W'(r_ly);
    end else begin
      w_num = NUM_W'(r_rx) - NUM_W'(r_lx);
    end
    w_neg       = w_num[NUM_W-1];
    w_dividend  = QW'(w_neg ? -w_num : w_num);
    w_divisor   = (r_state == FRAME_DIV) ? QW'(SRC_H - 1) : QW'(SRC_W - 1);
    w_div_start = ((r_state == FRAME_DIV) || (r_state == ROW_DIV)) && !w_div_busy;
    w_delta     = r_neg ? -$signed(ACC_W'(w_quo)) : $signed(ACC_W'(w_quo));
  end

  // Handshake and output-range decision for the current pixel.
  always_comb begin
    w_pix_ready = (r_state == STREAM) && (!r_valid || out_ready);
    w_accept    = w_pix_ready && pix_in_valid;
`ifdef CLIP_OUTPUT_EN
    w_emit = !r_px[ACC_W-1] && !r_py[ACC_W-1] &&
             !(|r_px[ACC_W-2:FRAC_BITS+X_BITS]) &&
             !(|r_py[ACC_W-2:FRAC_BITS+Y_BITS]);
`else
    w_emit = 1'b1;
`endif
  end

  seq_divider #(.W(QW)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  // Control FSM, accumulators and registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_d          <= '0;
      r_div_idx    <= '0;
      r_neg        <= 1'b0;
      r_lx         <= '0;
      r_ly         <= '0;
      r_rx         <= '0;
      r_ry         <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_dlx        <= '0;
      r_dly        <= '0;
      r_drx        <= '0;
      r_dry        <= '0;
      r_hx         <= '0;
      r_hy         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_pix        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_div_start) r_neg <= w_neg;

      if (w_accept) begin
        r_pix   <= pix_in;
        r_x     <= r_px[FRAC_BITS+X_BITS-1:FRAC_BITS];
        r_y     <= r_py[FRAC_BITS+Y_BITS-1:FRAC_BITS];
        r_valid <= w_emit;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (corners_valid) begin
            r_a.x     <= CRD_W'(a_x);
            r_a.y     <= CRD_W'(a_y);
            r_b.x     <= CRD_W'(b_x);
            r_b.y     <= CRD_W'(b_y);
            r_c.x     <= CRD_W'(c_x);
            r_c.y     <= CRD_W'(c_y);
            r_d.x     <= CRD_W'(d_x);
            r_d.y     <= CRD_W'(d_y);
            r_lx      <= ACC_W'(a_x) << FRAC_BITS;
            r_ly      <= ACC_W'(a_y) << FRAC_BITS;
            r_rx      <= ACC_W'(b_x) << FRAC_BITS;
            r_ry      <= ACC_W'(b_y) << FRAC_BITS;
            r_div_idx <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_state   <= FRAME_DIV;
          end
        end
        FRAME_DIV: begin
          if (w_div_done) begin
            case (r_div_idx)
              2'd0:    r_dlx <= w_delta;
              2'd1:    r_dly <= w_delta;
              2'd2:    r_drx <= w_delta;
              default: r_dry <= w_delta;
            endcase
            r_div_idx <= r_div_idx + 2'd1;
            if (r_div_idx == 2'd3) r_state <= ROW_DIV;
          end
        end
        ROW_DIV: begin
          if (w_div_done) begin
            if (!r_div_idx[0]) begin
              r_hx      <= w_delta;
              r_div_idx <= 2'd1;
            end else begin
              r_hy      <= w_delta;
              r_px      <= r_lx;
              r_py      <= r_ly;
              r_div_idx <= '0;
              r_state   <= STREAM;
            end
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_px <= r_px + r_hx;
            r_py <= r_py + r_hy;
            if (r_col == COL_W'(SRC_W - 1)) begin
              r_col <= '0;
              r_lx  <= r_lx + r_dlx;
              r_ly  <= r_ly + r_dly;
              r_rx  <= r_rx + r_drx;
              r_ry  <= r_ry + r_dry;
              if (r_row == ROW_W'(SRC_H - 1)) begin
                r_state <= DRAIN;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= ROW_DIV;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          // A clipped final pixel leaves nothing pending, so !r_valid also ends the frame.
          if (!r_valid || out_ready) begin
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign corners_ready = (r_state == IDLE);
  assign pix_in_ready  = w_pix_ready;
  assign pix_out       = r_pix;
  assign out_x         = r_x;
  assign out_y         = r_y;
  assign out_valid     = r_valid;
  assign frame_done    = r_frame_done;

endmodule
